// File: rtl/gen_mux_sel_seq.sv
// gen_mux_sel_seq
// Read-side bit-plane sequencer. Generates the plane select for the
// 1-to-NUM_SEL output mux and walks all planes of one stored matrix, one
// plane per GEN_RADDR_START pulse. Tracks which ping-pong bank is being read,
// waits for that bank's BANK_FULL flag, and hands the bank back with a
// one-hot release pulse once its final plane has been accepted.
//
// Ports
//   SYS_CLK          in   rising-edge clock
//   SYS_NRST         in   asynchronous active-low reset
//   ENABLE           in   sequencer runs while high
//   MODE_REV         in   plane order (0 up, 1 down), latched on WAIT->RUN
//   BANK_FULL        in   per-bank "complete matrix stored" level
//   GEN_RADDR_START  in   one-cycle pulse, one plane read
//   CTRL_BIT_SEL     out  current plane select
//   READ_BANK_SEL    out  bank being read or awaited
//   READ_ACTIVE      out  high while in RUN
//   READ_ONE_MATRIX  out  one-cycle pulse after the final plane
//   BANK_RELEASE     out  one-hot one-cycle pulse freeing the finished bank
//   START_ERR        out  sticky: start pulse seen outside RUN
module gen_mux_sel_seq #(
  parameter int SEL_W    = 3,
  parameter int NUM_SEL  = 8,
  parameter int BANK_W   = 1,
  parameter int NUM_BANK = 2
) (
  input  logic                SYS_CLK,
  input  logic                SYS_NRST,
  input  logic                ENABLE,
  input  logic                MODE_REV,
  input  logic [NUM_BANK-1:0] BANK_FULL,
  input  logic                GEN_RADDR_START,
  output logic [SEL_W-1:0]    CTRL_BIT_SEL,
  output logic [BANK_W-1:0]   READ_BANK_SEL,
  output logic                READ_ACTIVE,
  output logic                READ_ONE_MATRIX,
  output logic [NUM_BANK-1:0] BANK_RELEASE,
  output logic                START_ERR
);

  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_SEL - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                rev_reg, rev_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [BANK_W-1:0]   bank_reg, bank_next;
  logic                active_reg, active_next;
  logic                matrix_reg, matrix_next;
  logic [NUM_BANK-1:0] release_reg, release_next;
  logic                err_reg, err_next;

  logic accept;
  logic last_plane;
  logic finish;

  assign accept     = (state_reg == RUN) && GEN_RADDR_START;
  // The last plane depends on the order latched at RUN entry, not on MODE_REV.
  assign last_plane = rev_reg ? (sel_reg == '0) : (sel_reg == SEL_LAST);
  assign finish     = accept && last_plane;

  // State and output registers
  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_reg   <= IDLE;
      rev_reg     <= 1'b0;
      sel_reg     <= '0;
      bank_reg    <= '0;
      active_reg  <= 1'b0;
      matrix_reg  <= 1'b0;
      release_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rev_reg     <= rev_next;
      sel_reg     <= sel_next;
      bank_reg    <= bank_next;
      active_reg  <= active_next;
      matrix_reg  <= matrix_next;
      release_reg <= release_next;
      err_reg     <= err_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (ENABLE) state_next = WAIT;
      WAIT: begin
        if (BANK_FULL[bank_reg]) state_next = RUN;
        else if (!ENABLE)        state_next = IDLE;
      end
      // ENABLE is only looked at once the matrix is done, so a falling
      // ENABLE never aborts a matrix half-way through.
      RUN:  if (finish) state_next = ENABLE ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    rev_next    = rev_reg;
    sel_next    = sel_reg;
    bank_next   = bank_reg;
    matrix_next = 1'b0;
    err_next    = err_reg;
    active_next = (state_next == RUN);

    if ((state_reg == WAIT) && (state_next == RUN)) begin
      rev_next = MODE_REV;
      sel_next = MODE_REV ? SEL_LAST : '0;
    end

    if (accept) begin
      if (last_plane) begin
        // Select holds its final value; only the bank pointer moves on.
        matrix_next = 1'b1;
        bank_next   = (bank_reg == BANK_LAST) ? '0 : bank_reg + BANK_W'(1);
      end else begin
        sel_next = rev_reg ? sel_reg - SEL_W'(1) : sel_reg + SEL_W'(1);
      end
    end

    if (GEN_RADDR_START && (state_reg != RUN))
      err_next = 1'b1;
    else if ((state_reg == IDLE) && !ENABLE)
      err_next = 1'b0;
  end

  // One-hot release of the bank whose matrix just finished
  generate
    for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_release
      assign release_next[gi] = finish && (bank_reg == BANK_W'(gi));
    end
  endgenerate

  assign CTRL_BIT_SEL    = sel_reg;
  assign READ_BANK_SEL   = bank_reg;
  assign READ_ACTIVE     = active_reg;
  assign READ_ONE_MATRIX = matrix_reg;
  assign BANK_RELEASE    = release_reg;
  assign START_ERR       = err_reg;

endmodule

// File: tb/tb_gen_mux_sel_seq.sv
module tb_gen_mux_sel_seq;

  logic       clk = 1'b0;
  logic       rst_n;

  // Default build (NUM_SEL = 8)
  logic       enable, mode_rev, start;
  logic [1:0] bank_full;
  logic [2:0] sel;
  logic       bank_sel, active, matrix, err;
  logic [1:0] rel;

  // NUM_SEL = 5 build
  logic       enable5, mode_rev5, start5;
  logic [1:0] bank_full5;
  logic [2:0] sel5;
  logic       bank_sel5, active5, matrix5, err5;
  logic [1:0] rel5;

  int checks = 0;
  int errors = 0;
  logic [1:0] st;

  always #5 clk = ~clk;

  gen_mux_sel_seq dut (
    .SYS_CLK(clk), .SYS_NRST(rst_n), .ENABLE(enable), .MODE_REV(mode_rev),
    .BANK_FULL(bank_full), .GEN_RADDR_START(start),
    .CTRL_BIT_SEL(sel), .READ_BANK_SEL(bank_sel), .READ_ACTIVE(active),
    .READ_ONE_MATRIX(matrix), .BANK_RELEASE(rel), .START_ERR(err)
  );

  gen_mux_sel_seq #(.SEL_W(3), .NUM_SEL(5), .BANK_W(1), .NUM_BANK(2)) dut5 (
    .SYS_CLK(clk), .SYS_NRST(rst_n), .ENABLE(enable5), .MODE_REV(mode_rev5),
    .BANK_FULL(bank_full5), .GEN_RADDR_START(start5),
    .CTRL_BIT_SEL(sel5), .READ_BANK_SEL(bank_sel5), .READ_ACTIVE(active5),
    .READ_ONE_MATRIX(matrix5), .BANK_RELEASE(rel5), .START_ERR(err5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_active();
    for (int i = 0; i < 20 && !active; i++) tick();
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL wait_active: READ_ACTIVE=%b required 1 within 20 cycles", active);
    end
  endtask

  task automatic wait_active5();
    for (int i = 0; i < 20 && !active5; i++) tick();
    checks++;
    if (active5 !== 1'b1) begin
      errors++;
      $display("FAIL wait_active5: READ_ACTIVE=%b required 1 within 20 cycles", active5);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 0; mode_rev = 0; start = 0; bank_full = 2'b00;
    enable5 = 0; mode_rev5 = 0; start5 = 0; bank_full5 = 2'b00;
    #3;
    checks++;
    if ({sel, bank_sel, active, matrix, rel, err} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {sel, bank_sel, active, matrix, rel, err});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    st = dut.state_reg;
    checks++;
    if (st !== 2'd0 || active !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: state=%0d active=%b required IDLE(0) active=0", st, active);
    end
  endtask

  task automatic test_forward();
    enable = 1; bank_full = 2'b01; mode_rev = 0;
    wait_active();
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (sel !== 3'(p)) begin
        errors++;
        $display("FAIL fwd_sel: plane %0d sel=%0d required %0d", p, sel, p);
      end
      start = 1; tick(); start = 0;
      $display("fwd plane %0d accepted, sel now %0d", p, sel);
      if (p < 7) begin
        checks++;
        if (sel !== 3'(p + 1) || matrix !== 1'b0 || active !== 1'b1) begin
          errors++;
          $display("FAIL fwd_step: sel=%0d matrix=%b active=%b required %0d 0 1", sel, matrix, active, p + 1);
        end
        tick(); tick();
      end else begin
        st = dut.state_reg;
        checks++;
        if (matrix !== 1'b1 || rel !== 2'b01 || active !== 1'b0 || bank_sel !== 1'b1 || sel !== 3'd7 || st !== 2'd1) begin
          errors++;
          $display("FAIL fwd_done: matrix=%b rel=%b active=%b bank=%b sel=%0d state=%0d required 1 01 0 1 7 1",
                   matrix, rel, active, bank_sel, sel, st);
        end
        tick();
        st = dut.state_reg;
        checks++;
        if (matrix !== 1'b0 || rel !== 2'b00 || st !== 2'd1 || err !== 1'b0) begin
          errors++;
          $display("FAIL fwd_pulse_width: matrix=%b rel=%b state=%0d err=%b required 0 00 1 0", matrix, rel, st, err);
        end
      end
    end
  endtask

  task automatic test_reverse();
    mode_rev = 1; bank_full = 2'b10;
    wait_active();
    // Order must stay latched and a dropped BANK_FULL must not abort RUN.
    mode_rev = 0; bank_full = 2'b00;
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (sel !== 3'(7 - p) || active !== 1'b1) begin
        errors++;
        $display("FAIL rev_sel: plane %0d sel=%0d active=%b required %0d 1", p, sel, active, 7 - p);
      end
      start = 1; tick(); start = 0;
      $display("rev plane %0d accepted, sel now %0d", p, sel);
      if (p == 7) begin
        checks++;
        if (matrix !== 1'b1 || rel !== 2'b10 || bank_sel !== 1'b0 || sel !== 3'd0) begin
          errors++;
          $display("FAIL rev_done: matrix=%b rel=%b bank=%b sel=%0d required 1 10 0 0", matrix, rel, bank_sel, sel);
        end
      end else begin
        tick();
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int planes = 0;
    int mc = 0;
    int mt[2];
    mt[0] = 0; mt[1] = 0;
    bank_full = 2'b11; mode_rev = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (matrix) begin
        mt[mc] = cyc;
        mc++;
        $display("b2b matrix pulse %0d at cycle %0d", mc, cyc);
      end
      if (mc == 2) begin
        start = 0;
        break;
      end
      if (mc == 1 && cyc == mt[0]) begin
        checks++;
        if (active !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap_low: active=%b required 0", active);
        end
      end
      if (mc == 1 && cyc == mt[0] + 1) begin
        checks++;
        if (active !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap_len: active=%b required 1 after one WAIT cycle", active);
        end
      end
      if (mc == 1 && active) bank_full = 2'b00;
      if (active) begin
        checks++;
        if (sel !== 3'(planes % 8)) begin
          errors++;
          $display("FAIL b2b_sel: plane %0d sel=%0d required %0d", planes, sel, planes % 8);
        end
        planes++;
        start = 1;
      end else begin
        start = 0;
      end
    end
    start = 0;
    checks++;
    if (planes !== 16 || mc !== 2 || (mt[1] - mt[0]) !== 9) begin
      errors++;
      $display("FAIL b2b_totals: planes=%0d pulses=%0d spacing=%0d required 16 2 9", planes, mc, mt[1] - mt[0]);
    end
    tick();
  endtask

  task automatic test_graceful_stop();
    bank_full = 2'b01;
    wait_active();
    for (int p = 0; p < 8; p++) begin
      if (p == 3) enable = 0;
      checks++;
      if (sel !== 3'(p) || active !== 1'b1) begin
        errors++;
        $display("FAIL stop_sel: plane %0d sel=%0d active=%b required %0d 1", p, sel, active, p);
      end
      start = 1; tick(); start = 0;
      if (p < 7) tick();
    end
    st = dut.state_reg;
    checks++;
    if (matrix !== 1'b1 || active !== 1'b0 || st !== 2'd0 || bank_sel !== 1'b1) begin
      errors++;
      $display("FAIL stop_done: matrix=%b active=%b state=%0d bank=%b required 1 0 0 1", matrix, active, st, bank_sel);
    end
    bank_full = 2'b00;
    tick();
    enable = 1; start = 1; tick(); start = 0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: START_ERR=%b required 1", err);
    end
    tick(); tick(); tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: START_ERR=%b required 1", err);
    end
    enable = 0;
    tick(); tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: START_ERR=%b required 0", err);
    end
  endtask

  task automatic test_num_sel5();
    enable5 = 1; bank_full5 = 2'b01; mode_rev5 = 0;
    wait_active5();
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (sel5 !== 3'(p) || sel5 > 3'd4) begin
        errors++;
        $display("FAIL n5_fwd_sel: plane %0d sel=%0d required %0d", p, sel5, p);
      end
      start5 = 1; tick();
    end
    start5 = 0;
    checks++;
    if (matrix5 !== 1'b1 || sel5 !== 3'd4 || bank_sel5 !== 1'b1 || rel5 !== 2'b01) begin
      errors++;
      $display("FAIL n5_fwd_done: matrix=%b sel=%0d bank=%b rel=%b required 1 4 1 01", matrix5, sel5, bank_sel5, rel5);
    end
    mode_rev5 = 1; bank_full5 = 2'b10;
    wait_active5();
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (sel5 !== 3'(4 - p) || sel5 > 3'd4) begin
        errors++;
        $display("FAIL n5_rev_sel: plane %0d sel=%0d required %0d", p, sel5, 4 - p);
      end
      start5 = 1; tick();
    end
    start5 = 0;
    checks++;
    if (matrix5 !== 1'b1 || sel5 !== 3'd0 || rel5 !== 2'b10 || err5 !== 1'b0) begin
      errors++;
      $display("FAIL n5_rev_done: matrix=%b sel=%0d rel=%b err=%b required 1 0 10 0", matrix5, sel5, rel5, err5);
    end
    bank_full5 = 2'b00; enable5 = 0;
    tick();
  endtask

  task automatic test_async_reset();
    enable = 1; bank_full = 2'b10; mode_rev = 0;
    wait_active();
    for (int p = 0; p < 5; p++) begin
      start = 1; tick();
    end
    start = 0;
    checks++;
    if (sel !== 3'd5) begin
      errors++;
      $display("FAIL arst_pre: sel=%0d required 5", sel);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, bank_sel, active, matrix, rel, err} !== 9'd0) begin
      errors++;
      $display("FAIL arst_outputs: got %b required 0", {sel, bank_sel, active, matrix, rel, err});
    end
    #2 rst_n = 1'b1;
    bank_full = 2'b01;
    tick();
    checks++;
    if (active !== 1'b0 || bank_sel !== 1'b0 || rel !== 2'b00) begin
      errors++;
      $display("FAIL arst_wait: active=%b bank=%b rel=%b required 0 0 00", active, bank_sel, rel);
    end
    tick();
    checks++;
    if (active !== 1'b1 || sel !== 3'd0 || bank_sel !== 1'b0) begin
      errors++;
      $display("FAIL arst_run: active=%b sel=%0d bank=%b required 1 0 0", active, sel, bank_sel);
    end
    enable = 0; bank_full = 2'b00;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_back_to_back();
    test_graceful_stop();
    test_num_sel5();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
